// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED bar controller.
package led_bar_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MID   = 2'd1,
    ST_FULL  = 2'd2
  } lvl_state_e;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_DOT  = 1'b1;

  function automatic int unsigned level_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioning: synchronise, debounce, one-pulse and optional auto-repeat.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step_c
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RPT_W  = $clog2(REPEAT_CYCLES + 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              deb_q, deb_d;
  logic              deb_prev_q, deb_prev_d;
  logic              rpt_q, rpt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              rise;
  logic              rpt_fire;

  always_comb begin
    sync1_d    = btn;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_cnt_d  = '0;
    deb_prev_d = deb_q;
    hold_cnt_d = '0;
    rpt_cnt_d  = '0;
    rpt_d      = 1'b0;
    rpt_fire   = 1'b0;

    // Count consecutive cycles of disagreement; any agreement restarts it.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    rise = deb_q & ~deb_prev_q;

    // Hold phase waits HOLD_CYCLES after the edge pulse, then repeat phase ticks.
    if ((REPEAT_EN != 0) && deb_q) begin
      if (rise) begin
        hold_cnt_d = HOLD_W'(1);
      end else if (!rpt_q) begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
          rpt_fire  = 1'b1;
          rpt_d     = 1'b1;
          rpt_cnt_d = RPT_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end else begin
        rpt_d = 1'b1;
        if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES)) begin
          rpt_fire  = 1'b1;
          rpt_cnt_d = RPT_W'(1);
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
    end

    step_c = rise | rpt_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      rpt_q      <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      rpt_q      <= rpt_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
    end
  end

endmodule

// File: rtl/led_bar_ctrl.sv
// LED bar controller: button conditioners, level FSM, mode register and LED decode.
module led_bar_ctrl
  import led_bar_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned WRAP          = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_l,
  input  logic                      btn_r,
  input  logic                      btn_m,
  output logic [WIDTH-1:0]          led,
  output logic [level_w(WIDTH)-1:0] level,
  output logic                      mode,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned LW = level_w(WIDTH);
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

  logic step_l_c, step_r_c, step_m_c;

  lvl_state_e        state_q, state_d;
  logic [LW-1:0]     level_q, level_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  led_q, led_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(REPEAT_EN),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_cond_l (.clk(clk), .rst(rst), .btn(btn_l), .step_c(step_l_c));

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(REPEAT_EN),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_cond_r (.clk(clk), .rst(rst), .btn(btn_r), .step_c(step_r_c));

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(0),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_cond_m (.clk(clk), .rst(rst), .btn(btn_m), .step_c(step_m_c));

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    mode_d  = mode_q ^ step_m_c;
    led_d   = '0;

    // Simultaneous left/right steps cancel; end-of-range handled by explicit compare.
    if (step_l_c && !step_r_c) begin
      case (state_q)
        ST_FULL: if (WRAP != 0) level_d = '0;
        default: level_d = level_q + LW'(1);
      endcase
    end else if (step_r_c && !step_l_c) begin
      case (state_q)
        ST_EMPTY: if (WRAP != 0) level_d = LW'(WIDTH);
        default:  level_d = level_q - LW'(1);
      endcase
    end

    if (level_d == '0) begin
      state_d = ST_EMPTY;
    end else if (level_d == LW'(WIDTH)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_MID;
    end

    // Bar and dot both grow from the MSB end.
    if (mode_d == MODE_DOT) begin
      led_d = (level_d == '0) ? '0 : (MSB_ONLY >> (level_d - LW'(1)));
    end else begin
      led_d = ~(ONES >> level_d);
    end

    full_d  = (state_d == ST_FULL);
    empty_d = (state_d == ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      level_q <= '0;
      mode_q  <= MODE_FILL;
      led_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign mode  = mode_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Bench for led_bar_ctrl: saturating and wrapping instances against a cycle-history model.
module tb_led_bar_ctrl;

  localparam int W    = 8;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst, btn_l, btn_r, btn_m;
  logic [7:0] led0, led1;
  logic [3:0] lvl0, lvl1;
  logic mode0, mode1, full0, full1, empty0, empty1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_bar_ctrl #(
    .WIDTH(W), .DEB_CYCLES(DEB), .REPEAT_EN(1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .WRAP(0)
  ) dut (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .btn_m(btn_m),
    .led(led0), .level(lvl0), .mode(mode0), .full(full0), .empty(empty0)
  );

  led_bar_ctrl #(
    .WIDTH(W), .DEB_CYCLES(DEB), .REPEAT_EN(1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .WRAP(1)
  ) dut_w (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .btn_m(btn_m),
    .led(led1), .level(lvl1), .mode(mode1), .full(full1), .empty(empty1)
  );

  // Model: per-cycle histories of raw input, debounced level and step pulses.
  bit [2:0] raw_h [MAXC];
  bit [2:0] deb_h [MAXC];
  bit [2:0] pls_h [MAXC];
  int flip_h [3];
  int rise_h [3];
  int ncyc    = 0;
  int rst_cyc = 0;
  int lvl_nw  = 0;
  int lvl_w   = 0;
  bit exp_mode = 1'b0;

  function automatic bit sync_of(input int b, input int k);
    if (k - 2 >= rst_cyc) return raw_h[k-2][b];
    return 1'b0;
  endfunction

  function automatic int next_lvl(input int lv, input bit sl, input bit sr, input bit wrap);
    if (sl && !sr) return (lv == W) ? (wrap ? 0 : W) : lv + 1;
    if (sr && !sl) return (lv == 0) ? (wrap ? W : 0) : lv - 1;
    return lv;
  endfunction

  function automatic logic [7:0] led_of(input int lv, input bit md);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (md ? (lv >= 1 && i == W - lv) : (i >= W - lv)) v[i] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    forever begin
      int n, d;
      bit prv, nd, flip, rise, rep;
      @(posedge clk);
      ncyc++;
      n = ncyc;
      if (n < MAXC) begin
        raw_h[n-1] = {btn_m, btn_r, btn_l};
        if (rst) begin
          rst_cyc  = n;
          lvl_nw   = 0;
          lvl_w    = 0;
          exp_mode = 1'b0;
          deb_h[n] = '0;
          pls_h[n] = '0;
          for (int b = 0; b < 3; b++) flip_h[b] = n;
        end else begin
          lvl_nw   = next_lvl(lvl_nw, pls_h[n-1][0], pls_h[n-1][1], 1'b0);
          lvl_w    = next_lvl(lvl_w,  pls_h[n-1][0], pls_h[n-1][1], 1'b1);
          exp_mode = exp_mode ^ pls_h[n-1][2];
          for (int b = 0; b < 3; b++) begin
            prv  = deb_h[n-1][b];
            flip = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
              if (n - j < flip_h[b] || sync_of(b, n - j) == prv) flip = 1'b0;
            end
            nd = flip ? ~prv : prv;
            if (flip) flip_h[b] = n;
            deb_h[n][b] = nd;
            rise = nd & ~prv;
            if (rise) rise_h[b] = n;
            d   = n - rise_h[b];
            rep = (b < 2) && nd && prv && (d >= HOLD) && ((d - HOLD) % REP == 0);
            pls_h[n][b] = rise | rep;
          end
        end
      end
    end
  end

  task automatic cmp_dut(input string nm, input logic [7:0] a_led, input logic [3:0] a_lvl,
                         input logic a_mode, input logic a_full, input logic a_empty,
                         input int e_lvl);
    logic [7:0] e_led;
    e_led = led_of(e_lvl, exp_mode);
    total++;
    if (a_led !== e_led || a_lvl !== 4'(e_lvl) || a_mode !== exp_mode ||
        a_full !== (e_lvl == W) || a_empty !== (e_lvl == 0)) begin
      bad++;
      $display("FAIL %s cyc=%0d got led=%h lvl=%0d mode=%b full=%b empty=%b want led=%h lvl=%0d mode=%b full=%b empty=%b",
               nm, ncyc, a_led, a_lvl, a_mode, a_full, a_empty,
               e_led, e_lvl, exp_mode, e_lvl == W, e_lvl == 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ncyc > 0 && ncyc < MAXC) begin
        cmp_dut("model_sat",  led0, lvl0, mode0, full0, empty0, lvl_nw);
        cmp_dut("model_wrap", led1, lvl1, mode1, full1, empty1, lvl_w);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int b, input int hold);
    case (b)
      0: btn_l = 1'b1;
      1: btn_r = 1'b1;
      default: btn_m = 1'b1;
    endcase
    tick(hold);
    btn_l = 1'b0;
    btn_r = 1'b0;
    btn_m = 1'b0;
    tick(12);
  endtask

  initial begin
    rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; btn_m = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    @(negedge clk);
    chk("rst_led", int'(led0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_level", int'(lvl0), 0);
    chk("rst_full", int'(full0), 0);
    chk("rst_mode", int'(mode0), 0);

    // Clean press: visible seven cycles after the raw edge.
    btn_l = 1'b1;
    tick(6);
    @(negedge clk);
    chk("press1_early_level", int'(lvl0), 0);
    tick(1);
    @(negedge clk);
    chk("press1_level", int'(lvl0), 1);
    chk("press1_led", int'(led0), 8'h80);
    tick(1);
    btn_l = 1'b0;
    tick(12);
    repeat (3) press(0, 8);
    @(negedge clk);
    chk("press4_led", int'(led0), 8'hF0);
    chk("press4_level", int'(lvl0), 4);

    // Bounce never stable long enough.
    btn_l = 1'b1; tick(2);
    btn_l = 1'b0; tick(1);
    btn_l = 1'b1; tick(2);
    btn_l = 1'b0; tick(15);
    @(negedge clk);
    chk("bounce_level", int'(lvl0), 4);

    // Coincident left and right.
    btn_l = 1'b1; btn_r = 1'b1;
    tick(8);
    btn_l = 1'b0; btn_r = 1'b0;
    tick(12);
    @(negedge clk);
    chk("coinc_level", int'(lvl0), 4);

    // Mode toggling.
    press(1, 8);
    press(2, 8);
    @(negedge clk);
    chk("dot_mode", int'(mode0), 1);
    chk("dot_led3", int'(led0), 8'h20);
    press(1, 8);
    @(negedge clk);
    chk("dot_led2", int'(led0), 8'h40);
    chk("dot_level2", int'(lvl0), 2);
    press(2, 8);
    @(negedge clk);
    chk("fill_led2", int'(led0), 8'hC0);

    // Step down from empty: saturate vs wrap.
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    press(1, 8);
    @(negedge clk);
    chk("sat_empty_level", int'(lvl0), 0);
    chk("sat_empty_flag", int'(empty0), 1);
    chk("wrap_empty_level", int'(lvl1), 8);
    chk("wrap_empty_full", int'(full1), 1);
    chk("wrap_empty_led", int'(led1), 8'hFF);

    // Held button: hold delay, repeat rate, saturation / wrap.
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    btn_l = 1'b1;
    tick(7);
    @(negedge clk);
    chk("hold_first", int'(lvl0), 1);
    tick(19);
    @(negedge clk);
    chk("hold_before_rep", int'(lvl0), 1);
    tick(1);
    @(negedge clk);
    chk("hold_first_rep", int'(lvl0), 2);
    tick(5);
    @(negedge clk);
    chk("hold_second_rep", int'(lvl0), 3);
    tick(25);
    @(negedge clk);
    chk("hold_sat_level", int'(lvl0), 8);
    chk("hold_sat_full", int'(full0), 1);
    tick(3);
    btn_l = 1'b0;
    tick(2);
    @(negedge clk);
    chk("hold_sat_stays", int'(lvl0), 8);
    chk("hold_wrap_zero", int'(lvl1), 0);
    chk("hold_wrap_empty", int'(empty1), 1);
    tick(12);

    // Reset while repeating; held button must debounce again.
    btn_l = 1'b1;
    tick(35);
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    chk("midrep_rst_level", int'(lvl0), 0);
    chk("midrep_rst_led", int'(led0), 0);
    chk("midrep_rst_empty", int'(empty0), 1);
    rst = 1'b0;
    tick(6);
    @(negedge clk);
    chk("midrep_no_early", int'(lvl0), 0);
    tick(1);
    @(negedge clk);
    chk("midrep_repulse", int'(lvl0), 1);
    chk("midrep_led", int'(led0), 8'h80);
    btn_l = 1'b0;
    tick(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_bar_ctrl.md
# led_bar_ctrl

Parametrised LED bar controller driven by raw push-buttons. Left and right buttons step a bar level up or down, and a mode button switches the display between a filled bar and a single moving dot. Each button passes through synchronise, debounce, one-pulse and optional auto-repeat conditioning. The block sits between the board buttons and the LED pins in lab top levels.

## Interface
- `WIDTH`, 16: number of LEDs; level range is 0..WIDTH.
- `DEB_CYCLES`, 1_000_000: cycles the synchronised input must be stable before the debounced level changes (≥1).
- `REPEAT_EN`, 1: enables auto-repeat on held left/right buttons.
- `HOLD_CYCLES`, 50_000_000: cycles held after the first step before repeating starts.
- `REPEAT_CYCLES`, 10_000_000: cycles between repeated steps.
- `WRAP`, 0: 1 = level wraps at both ends; 0 = level saturates.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset (not debounced).
- `btn_l`  in  1  raw left button; increases level.
- `btn_r`  in  1  raw right button; decreases level.
- `btn_m`  in  1  raw mode button; toggles mode (never repeats).
- `led`  out  WIDTH  registered LED pattern.
- `level`  out  $clog2(WIDTH+1)  current level.
- `mode`  out  1  0 = FILL, 1 = DOT.
- `full`  out  1  high when level == WIDTH.
- `empty`  out  1  high when level == 0.

## Operation
- Reset values: `level`=0, `mode`=0, `led`=0, `empty`=1, `full`=0. All conditioner state is cleared: sync flops, debounced level and counters all 0.
- Conditioner, per button:
  - 2-flop synchroniser.
  - Debounce counter: the debounced level takes the synchronised value once it has differed from the debounced level for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - One-pulse: a single-cycle `step` pulse on each debounced rising edge.
- Auto-repeat (left/right only, REPEAT_EN=1):
  - While the debounced level stays high, one further pulse follows HOLD_CYCLES after the edge pulse.
  - After that, one pulse every REPEAT_CYCLES.
  - Release stops repeating immediately and clears the counter.
- Level state machine, states EMPTY (level 0), MID, FULL (level WIDTH):
  - step_l: level+1. From FULL: WRAP=1 goes to 0/EMPTY; WRAP=0 ignores the step.
  - step_r: level−1. From EMPTY: WRAP=1 goes to WIDTH/FULL; WRAP=0 ignores the step.
  - step_l and step_r in the same cycle: no change.
  - MID→EMPTY/FULL and back are decided purely by the resulting level.
- Mode: a step_m pulse toggles `mode`. `level` is preserved across toggles. A mode pulse coinciding with a step applies both in the same cycle.
- LED decode, from the registered next level/mode:
  - FILL: bits WIDTH−1 down to WIDTH−level are set, all others clear (the bar grows from the MSB end).
  - DOT: only bit WIDTH−level is set when level ≥ 1; `led`=0 when level = 0.
- Reset mid-debounce or mid-repeat abandons the press. A button still held after reset release must be seen stable again before it produces a pulse.

## Timing
- A raw rising edge held stable from cycle 0 produces the step pulse in cycle DEB_CYCLES+2.
- `level`, `led`, `full`, `empty` and `mode` update at the next edge, so they are visible in cycle DEB_CYCLES+3.
- First repeat pulse: HOLD_CYCLES after the edge pulse. Subsequent repeats: every REPEAT_CYCLES.
- All outputs are registered; there is no combinational input-to-output path.
- Width rules:
  - `level` is computed at $clog2(WIDTH+1) bits.
  - Counters are sized $clog2(max+1) of their own parameter.
  - Wrap is done by explicit compare, never by overflow.

## Structure
- A shared package `led_bar_pkg` holds:
  - the state encoding enum (EMPTY, MID, FULL);
  - the mode constants FILL/DOT;
  - a `level_w(WIDTH)` function.
- Sub-module `btn_conditioner`: sync, debounce, one-pulse and repeat logic, with `REPEAT_EN` as its own parameter. It is instantiated three times; the mode button uses REPEAT_EN=0.
- The top level holds the level FSM, mode register and LED decode.

## Test plan
Bench parameters: WIDTH=8, DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
- Reset then idle → `led`=0x00, `empty`=1, `level`=0.
- Clean btn_l press → `level`=1, `led`=0x80 at cycle 7. Three further presses → `led`=0xF0.
- Bounce btn_l (high 2, low 1, high 2 cycles) then release → no step; `level` unchanged.
- btn_l held 60 cycles → level goes 1, then 2 at +20 cycles, then 3, 4, 5, 6, 7 every 5 cycles, saturating at 8 with `full`=1 (WRAP=0).
  - With WRAP=1, the step after level 8 gives 0.
- At level 3 press btn_m → `mode`=1, `led`=0x20. Then btn_r → `led`=0x40, `level`=2.
- btn_l and btn_r pulses coincident at level 4 → level stays 4.
- `rst` asserted while btn_l held mid-repeat → outputs return to reset values. A pulse reappears only after DEB_CYCLES stable cycles.
